// File: rtl/freq_meter_if.sv
// Signal-under-test and measurement-result bundle for freq_meter.
// master drives enable/stimulus and observes results; slave is the meter.
interface freq_meter_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] freq_count;
    logic [CNT_W-1:0] period_cycles;
    logic             valid;
    logic             period_valid;
    logic             no_signal;
    logic             edge_ovf;

    modport master (
        output en,
        output sig_in,
        input  freq_count,
        input  period_cycles,
        input  valid,
        input  period_valid,
        input  no_signal,
        input  edge_ovf
    );

    modport slave (
        input  en,
        input  sig_in,
        output freq_count,
        output period_cycles,
        output valid,
        output period_valid,
        output no_signal,
        output edge_ovf
    );
endinterface

// File: rtl/freq_meter.sv
// Frequency/period meter for a slow strobe: counts rising edges per fixed gate window and
// measures clk cycles between consecutive rising edges.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    freq_meter_if.slave  bus
);
    localparam logic [CNT_W-1:0] CntMax   = '1;
    // GATE_CYCLES must be >= 2 and representable in CNT_W bits.
    localparam logic [CNT_W-1:0] GateLast = CNT_W'(GATE_CYCLES - 1);

    logic sync1_q, sync2_q, dly_q;

    logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             first_seen_q, first_seen_d;

    logic [CNT_W-1:0] freq_count_q, freq_count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             period_valid_q, period_valid_d;
    logic             no_signal_q, no_signal_d;
    logic             edge_ovf_q, edge_ovf_d;

    logic             edge_det;
    logic             gate_last;
    logic             edge_sat;
    logic [CNT_W-1:0] edge_sum;
    logic [CNT_W-1:0] per_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= bus.sig_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign edge_det  = bus.en & sync2_q & ~dly_q;
    assign gate_last = bus.en && (gate_cnt_q == GateLast);
    assign edge_sat  = edge_det && (edge_cnt_q == CntMax);
    assign edge_sum  = edge_sat ? CntMax : edge_cnt_q + {{(CNT_W-1){1'b0}}, edge_det};
    assign per_inc   = (per_cnt_q == CntMax) ? CntMax : per_cnt_q + 1'b1;

    always_comb begin
        gate_cnt_d     = gate_cnt_q;
        edge_cnt_d     = edge_cnt_q;
        per_cnt_d      = per_cnt_q;
        ovf_pend_d     = ovf_pend_q;
        first_seen_d   = first_seen_q;
        freq_count_d   = freq_count_q;
        period_d       = period_q;
        no_signal_d    = no_signal_q;
        edge_ovf_d     = edge_ovf_q;
        valid_d        = 1'b0;
        period_valid_d = 1'b0;

        if (!bus.en) begin
            gate_cnt_d   = '0;
            edge_cnt_d   = '0;
            per_cnt_d    = '0;
            ovf_pend_d   = 1'b0;
            first_seen_d = 1'b0;
        end else begin
            per_cnt_d = per_inc;
            if (edge_det) begin
                // The first edge after reset or enable only arms the period measurement.
                if (first_seen_q) begin
                    period_d       = per_inc;
                    period_valid_d = 1'b1;
                end
                per_cnt_d    = '0;
                first_seen_d = 1'b1;
            end

            if (gate_last) begin
                // An edge landing on the terminal cycle belongs to the closing window.
                gate_cnt_d   = '0;
                freq_count_d = edge_sum;
                no_signal_d  = (edge_sum == '0);
                edge_ovf_d   = ovf_pend_q | edge_sat;
                edge_cnt_d   = '0;
                ovf_pend_d   = 1'b0;
                valid_d      = 1'b1;
            end else begin
                gate_cnt_d = gate_cnt_q + 1'b1;
                edge_cnt_d = edge_sum;
                ovf_pend_d = ovf_pend_q | edge_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_cnt_q     <= '0;
            edge_cnt_q     <= '0;
            per_cnt_q      <= '0;
            ovf_pend_q     <= 1'b0;
            first_seen_q   <= 1'b0;
            freq_count_q   <= '0;
            period_q       <= '0;
            valid_q        <= 1'b0;
            period_valid_q <= 1'b0;
            no_signal_q    <= 1'b0;
            edge_ovf_q     <= 1'b0;
        end else begin
            gate_cnt_q     <= gate_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            per_cnt_q      <= per_cnt_d;
            ovf_pend_q     <= ovf_pend_d;
            first_seen_q   <= first_seen_d;
            freq_count_q   <= freq_count_d;
            period_q       <= period_d;
            valid_q        <= valid_d;
            period_valid_q <= period_valid_d;
            no_signal_q    <= no_signal_d;
            edge_ovf_q     <= edge_ovf_d;
        end
    end

    assign bus.freq_count    = freq_count_q;
    assign bus.period_cycles = period_q;
    assign bus.valid         = valid_q;
    assign bus.period_valid  = period_valid_q;
    assign bus.no_signal     = no_signal_q;
    assign bus.edge_ovf      = edge_ovf_q;
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: stimulus queues expected result pulses (with the cycle they
// must appear on), a negedge monitor pops and compares whenever valid/period_valid pulse.
module tb_freq_meter;
    localparam int unsigned GATE = 1000;
    localparam int unsigned W    = 16;

    logic clk = 1'b0;
    logic rst;

    freq_meter_if #(.CNT_W(W)) m_if ();

    freq_meter #(
        .GATE_CYCLES(GATE),
        .CNT_W      (W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(m_if.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int fc;
        int ns;
        int ovf;
    } vexp_t;

    typedef struct {
        int cyc;
        int per;
    } pexp_t;

    vexp_t vq[$];
    pexp_t pq[$];

    int total = 0;
    int bad   = 0;
    int zero_req  = 0;
    int zero_done = 0;
    bit done = 1'b0;
    bit sig_run = 1'b0;
    int ph = 0;
    int c0 = 0;
    int c1 = 0;

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        vexp_t ve;
        pexp_t pe;
        if (zero_req != zero_done) begin
            zero_done = zero_req;
            chk("rst_freq_count", int'(m_if.freq_count), 0);
            chk("rst_period_cycles", int'(m_if.period_cycles), 0);
            chk("rst_valid", int'(m_if.valid), 0);
            chk("rst_period_valid", int'(m_if.period_valid), 0);
            chk("rst_no_signal", int'(m_if.no_signal), 0);
            chk("rst_edge_ovf", int'(m_if.edge_ovf), 0);
        end
        if (m_if.valid) begin
            if (vq.size() == 0) begin
                chk("valid_unexpected_cycle", cyc, -1);
            end else begin
                ve = vq.pop_front();
                chk("valid_cycle", cyc, ve.cyc);
                chk("freq_count", int'(m_if.freq_count), ve.fc);
                chk("no_signal", int'(m_if.no_signal), ve.ns);
                chk("edge_ovf", int'(m_if.edge_ovf), ve.ovf);
            end
        end
        if (m_if.period_valid) begin
            if (pq.size() == 0) begin
                chk("period_valid_unexpected_cycle", cyc, -1);
            end else begin
                pe = pq.pop_front();
                chk("period_valid_cycle", cyc, pe.cyc);
                chk("period_cycles", int'(m_if.period_cycles), pe.per);
            end
        end
        if (done) begin
            chk("valid_pulses_missing", vq.size(), 0);
            chk("period_pulses_missing", pq.size(), 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time 1000000");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        if (sig_run) begin
            m_if.sig_in = (ph < 5);
            ph = (ph + 1) % 10;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Async reset mid-cycle, release, then enable; c0 marks the enable negedge.
    task automatic start(input bit with_sig);
        @(posedge clk);
        #2;
        rst         = 1'b0;
        m_if.en     = 1'b0;
        sig_run     = 1'b0;
        m_if.sig_in = 1'b0;
        zero_req++;
        run(3);
        rst = 1'b1;
        run(3);
        m_if.en = 1'b1;
        if (with_sig) begin
            sig_run     = 1'b1;
            m_if.sig_in = 1'b1;
            ph          = 1;
        end
        c0 = cyc;
    endtask

    task automatic push_v(input int c, input int fc, input int ns, input int ovf);
        vexp_t e;
        e = '{c, fc, ns, ovf};
        vq.push_back(e);
    endtask

    // Period pulses of a 10-clk signal, every 10 cycles from first to last inclusive.
    task automatic push_periods(input int first, input int last);
        pexp_t e;
        for (int c = first; c <= last; c += 10) begin
            e = '{c, 10};
            pq.push_back(e);
        end
    endtask

    initial begin
        rst         = 1'b1;
        m_if.en     = 1'b0;
        m_if.sig_in = 1'b0;

        // Steady 10-clk signal: edges at gate_cnt 2+10k, 100 per window.
        start(1'b1);
        for (int m = 1; m <= 3; m++) push_v(c0 + 1000 * m, 100, 0, 0);
        push_periods(c0 + 13, c0 + 3005);
        run(3005);

        // Input held low for two windows.
        start(1'b0);
        push_v(c0 + 1000, 0, 1, 0);
        push_v(c0 + 2000, 0, 1, 0);
        run(2005);

        // Single rise detected on the terminal cycle gate_cnt==999.
        start(1'b0);
        push_v(c0 + 1000, 1, 0, 0);
        push_v(c0 + 2000, 0, 1, 0);
        run(997);
        m_if.sig_in = 1'b1;
        run(13);
        m_if.sig_in = 1'b0;
        run(995);

        // Enable dropped at gate_cnt=500 of the second window for 20 clk.
        start(1'b1);
        push_v(c0 + 1000, 100, 0, 0);
        push_periods(c0 + 13, c0 + 1500);
        run(1500);
        m_if.en = 1'b0;
        run(20);
        m_if.en = 1'b1;
        c1 = cyc;
        push_v(c1 + 1000, 100, 0, 0);
        push_periods(c1 + 13, c1 + 1005);
        run(1005);

        // Reset mid-window after freq_count=100, then the steady case again.
        start(1'b1);
        push_v(c0 + 1000, 100, 0, 0);
        push_periods(c0 + 13, c0 + 1500);
        run(1500);
        start(1'b1);
        push_v(c0 + 1000, 100, 0, 0);
        push_v(c0 + 2000, 100, 0, 0);
        push_periods(c0 + 13, c0 + 2005);
        run(2005);

        m_if.en = 1'b0;
        run(2);
        done = 1'b1;
        run(10);
    end
endmodule
